// File: rtl/uart_seg_decoder.sv
// rtl/uart_seg_decoder.sv - UART byte stream to multi-digit seven-segment frame decoder
// Optional feature macro: DISPLAY_RAW_EN (raw binary mode, two nibbles per byte)
module uart_seg_decoder #(
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_data_valid,
  input  logic [7:0]            rx_data_out,
  output logic [DIGITS-1:0]     data_en,
  output logic [4*DIGITS-1:0]   seg_data,
  output logic                  frame_done,
  output logic                  char_err
);

  localparam int CW = $clog2(DIGITS + 1);

  // Committed display state, shared by both modes
  logic [4*DIGITS-1:0] seg_q, seg_d;
  logic [DIGITS-1:0]   en_q, en_d;
  logic                fd_q, fd_d;

  assign seg_data   = seg_q;
  assign data_en    = en_q;
  assign frame_done = fd_q;

`ifdef DISPLAY_RAW_EN

  localparam logic [CW-1:0] HALF_LAST = CW'(DIGITS / 2 - 1);

  logic [CW-1:0]       bc_q, bc_d;
  logic [4*DIGITS-1:0] seg_shift;
  logic [DIGITS-1:0]   en_shift;

  // Each byte pushes two nibbles in from the right, high nibble first
  if (DIGITS == 2) begin : g_two
    assign seg_shift = rx_data_out;
    assign en_shift  = 2'b11;
  end else begin : g_wide
    assign seg_shift = {seg_q[4*DIGITS-9:0], rx_data_out};
    assign en_shift  = {en_q[DIGITS-3:0], 2'b11};
  end

  assign char_err = 1'b0;

  // Next state: write display directly, count bytes modulo DIGITS/2 for frame_done
  always_comb begin
    seg_d = seg_q;
    en_d  = en_q;
    bc_d  = bc_q;
    fd_d  = 1'b0;
    if (rx_data_valid) begin
      seg_d = seg_shift;
      en_d  = en_shift;
      if (bc_q == HALF_LAST) begin
        bc_d = '0;
        fd_d = 1'b1;
      end else begin
        bc_d = bc_q + CW'(1);
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      en_q  <= '0;
      bc_q  <= '0;
      fd_q  <= 1'b0;
    end else begin
      seg_q <= seg_d;
      en_q  <= en_d;
      bc_q  <= bc_d;
      fd_q  <= fd_d;
    end
  end

`else

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_e;

  localparam logic [CW-1:0] FULL_CNT = CW'(DIGITS);

  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
  logic [DIGITS-1:0]   sh_en_q, sh_en_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ce_q, ce_d;
  logic                is_hex;
  logic [3:0]          nib;

  assign char_err = ce_q;

  // Classify the incoming byte as a hex digit and map it to its nibble value
  always_comb begin
    is_hex = 1'b0;
    nib    = 4'h0;
    if (rx_data_out >= 8'h30 && rx_data_out <= 8'h39) begin
      is_hex = 1'b1;
      nib    = rx_data_out[3:0];
    end else if ((rx_data_out >= 8'h41 && rx_data_out <= 8'h46) ||
                 (rx_data_out >= 8'h61 && rx_data_out <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = rx_data_out[3:0] + 4'd9;
    end
  end

  // Next state: edit the shadow buffer, commit it to the display on CR
  always_comb begin
    state_d   = state_q;
    sh_data_d = sh_data_q;
    sh_en_d   = sh_en_q;
    cnt_d     = cnt_q;
    seg_d     = seg_q;
    en_d      = en_q;
    fd_d      = 1'b0;
    ce_d      = 1'b0;
    if (rx_data_valid) begin
      if (is_hex) begin
        sh_data_d = {sh_data_q[4*DIGITS-5:0], nib};
        sh_en_d   = {sh_en_q[DIGITS-2:0], 1'b1};
        // When full the oldest digit falls off the left and the count saturates
        if (state_q != ST_FULL) begin
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q + CW'(1) == FULL_CNT) ? ST_FULL : ST_PARTIAL;
        end
      end else begin
        case (rx_data_out)
          8'h08: begin
            if (state_q != ST_EMPTY) begin
              sh_data_d = sh_data_q >> 4;
              sh_en_d   = sh_en_q >> 1;
              cnt_d     = cnt_q - CW'(1);
              state_d   = (cnt_q == CW'(1)) ? ST_EMPTY : ST_PARTIAL;
            end
          end
          8'h0D: begin
            seg_d     = sh_data_q;
            en_d      = sh_en_q;
            fd_d      = 1'b1;
            sh_data_d = '0;
            sh_en_d   = '0;
            cnt_d     = '0;
            state_d   = ST_EMPTY;
          end
          8'h1B: begin
            seg_d     = '0;
            en_d      = '0;
            sh_data_d = '0;
            sh_en_d   = '0;
            cnt_d     = '0;
            state_d   = ST_EMPTY;
          end
          8'h0A: ;
          default: ce_d = 1'b1;
        endcase
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      sh_data_q <= '0;
      sh_en_q   <= '0;
      cnt_q     <= '0;
      seg_q     <= '0;
      en_q      <= '0;
      fd_q      <= 1'b0;
      ce_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_data_q <= sh_data_d;
      sh_en_q   <= sh_en_d;
      cnt_q     <= cnt_d;
      seg_q     <= seg_d;
      en_q      <= en_d;
      fd_q      <= fd_d;
      ce_q      <= ce_d;
    end
  end

`endif

endmodule

// File: tb/tb_uart_seg_decoder.sv
// tb/tb_uart_seg_decoder.sv - table-driven bench for uart_seg_decoder (DIGITS=8)
module tb_uart_seg_decoder;

  logic        clk;
  logic        rst_n;
  logic        rx_data_valid;
  logic [7:0]  rx_data_out;
  logic [7:0]  data_en;
  logic [31:0] seg_data;
  logic        frame_done;
  logic        char_err;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic [31:0] seg;
    logic [7:0]  en;
    logic        fd;
    logic        ce;
  } vec_t;

  vec_t tbl[$];

  uart_seg_decoder #(.DIGITS(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data_valid (rx_data_valid),
    .rx_data_out   (rx_data_out),
    .data_en       (data_en),
    .seg_data      (seg_data),
    .frame_done    (frame_done),
    .char_err      (char_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] b, input logic [31:0] seg,
                     input logic [7:0] en, input logic fd, input logic ce);
    vec_t e;
    e.v = v; e.b = b; e.seg = seg; e.en = en; e.fd = fd; e.ce = ce;
    tbl.push_back(e);
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] seg, input logic [7:0] en,
                               input logic fd, input logic ce);
    chk({tag, ".seg"}, seg_data, seg);
    chk({tag, ".en"}, {24'h0, data_en}, {24'h0, en});
    chk({tag, ".fd"}, {31'h0, frame_done}, {31'h0, fd});
    chk({tag, ".ce"}, {31'h0, char_err}, {31'h0, ce});
  endtask

  // Strobes are driven back-to-back, one table row per clock
  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      rx_data_valid = tbl[i].v;
      rx_data_out   = tbl[i].b;
      @(posedge clk);
      #1;
      check_outputs($sformatf("%s[%0d]", tag, i), tbl[i].seg, tbl[i].en, tbl[i].fd, tbl[i].ce);
    end
    rx_data_valid = 1'b0;
    rx_data_out   = 8'h00;
    tbl.delete();
  endtask

  initial begin
    rst_n         = 1'b0;
    rx_data_valid = 1'b0;
    rx_data_out   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 32'h0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

`ifdef DISPLAY_RAW_EN
    add(1, 8'h12, 32'h00000012, 8'h03, 0, 0);
    add(1, 8'h34, 32'h00001234, 8'h0F, 0, 0);
    add(1, 8'h56, 32'h00123456, 8'h3F, 0, 0);
    add(1, 8'h78, 32'h12345678, 8'hFF, 1, 0);
    add(0, 8'h00, 32'h12345678, 8'hFF, 0, 0);
    add(1, 8'h9A, 32'h3456789A, 8'hFF, 0, 0);
    add(1, 8'hBC, 32'h56789ABC, 8'hFF, 0, 0);
    add(1, 8'hDE, 32'h789ABCDE, 8'hFF, 0, 0);
    add(1, 8'hF0, 32'h9ABCDEF0, 8'hFF, 1, 0);
    run_table("raw");
`else
    // "12AB" then CR: nothing shown until the commit
    add(1, "1",   32'h0,        8'h00, 0, 0);
    add(1, "2",   32'h0,        8'h00, 0, 0);
    add(1, "A",   32'h0,        8'h00, 0, 0);
    add(1, "B",   32'h0,        8'h00, 0, 0);
    add(1, 8'h0D, 32'h000012AB, 8'h0F, 1, 0);
    add(0, 8'h00, 32'h000012AB, 8'h0F, 0, 0);
    run_table("t12ab");

    // Nine digits wrap: oldest digit dropped
    for (int i = 1; i <= 9; i++) add(1, 8'h30 + 8'(i), 32'h000012AB, 8'h0F, 0, 0);
    add(1, 8'h0D, 32'h23456789, 8'hFF, 1, 0);
    run_table("twrap");

    // Backspace past empty is harmless; lowercase hex accepted
    add(1, "1",   32'h23456789, 8'hFF, 0, 0);
    add(1, "2",   32'h23456789, 8'hFF, 0, 0);
    add(1, 8'h08, 32'h23456789, 8'hFF, 0, 0);
    add(1, 8'h08, 32'h23456789, 8'hFF, 0, 0);
    add(1, 8'h08, 32'h23456789, 8'hFF, 0, 0);
    add(1, "f",   32'h23456789, 8'hFF, 0, 0);
    add(1, 8'h0D, 32'h0000000F, 8'h01, 1, 0);
    run_table("tbs");

    // Bad char, LF ignored, blank frame on empty CR, ESC clears display
    add(1, "G",   32'h0000000F, 8'h01, 0, 1);
    add(1, 8'h0A, 32'h0000000F, 8'h01, 0, 0);
    add(1, 8'h0D, 32'h00000000, 8'h00, 1, 0);
    add(1, "5",   32'h00000000, 8'h00, 0, 0);
    add(1, 8'h0D, 32'h00000005, 8'h01, 1, 0);
    add(1, "7",   32'h00000005, 8'h01, 0, 0);
    add(1, 8'h1B, 32'h00000000, 8'h00, 0, 0);
    add(1, 8'h0D, 32'h00000000, 8'h00, 1, 0);
    run_table("tesc");

    // Full buffer, backspace out of FULL, refill to FULL again
    for (int i = 1; i <= 8; i++) add(1, 8'h30 + 8'(i), 32'h0, 8'h00, 0, 0);
    add(1, 8'h08, 32'h0,        8'h00, 0, 0);
    add(1, "9",   32'h0,        8'h00, 0, 0);
    add(1, 8'h0D, 32'h12345679, 8'hFF, 1, 0);
    run_table("tfull");

    // Consecutive strobes, then asynchronous reset in the middle of a frame
    add(1, "9",   32'h12345679, 8'hFF, 0, 0);
    add(1, "8",   32'h12345679, 8'hFF, 0, 0);
    add(1, 8'h0D, 32'h00000098, 8'h03, 1, 0);
    add(1, "7",   32'h00000098, 8'h03, 0, 0);
    run_table("tb2b");
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 32'h0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    add(1, 8'h0D, 32'h00000000, 8'h00, 1, 0);
    add(1, "3",   32'h00000000, 8'h00, 0, 0);
    add(1, 8'h0D, 32'h00000003, 8'h01, 1, 0);
    run_table("tpost");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
